// File: rtl/ex_muldiv.sv
// ex_muldiv -- EX-stage multiply/divide unit owning the architectural HI/LO pair.
//
// Divide (DIV/DIVU) is restoring, one quotient bit per cycle on operand
// magnitudes, followed by a sign-fix cycle. MTHI/MTLO write in a single cycle.
// Multiply is single-cycle by default.
//
// Configuration macro: EX_MULDIV_ITER_MUL_EN
//   defined   -> MULT/MULTU run the shift-add path through the same FSM
//                (34-cycle latency, busy/done like divide).
//   undefined -> MULT/MULTU write {hi,lo} at the sampling edge.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   reset    in   synchronous active-high reset
//   start    in   issue op this cycle
//   op       in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   reg_a    in   rs operand (multiplicand / dividend / move source)
//   reg_b    in   rt operand (multiplier / divisor)
//   rd_hilo  in   MFHI/MFLO in EX
//   hi, lo   out  HI/LO registers
//   busy     out  multi-cycle operation in progress
//   stall    out  busy & (start | rd_hilo), combinational
//   done     out  one-cycle pulse when a multi-cycle result lands in HI/LO

module ex_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] reg_a,
    input  logic [31:0] reg_b,
    input  logic        rd_hilo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [5:0]  cnt_r;
    logic [63:0] acc_r;      // div: {remainder, quotient}; mul: {partial, multiplier}
    logic [31:0] opb_r;      // divisor or multiplicand magnitude
    logic        neg_q_r;    // negate quotient / product in FIX
    logic        neg_r_r;    // negate remainder in FIX
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;
`ifdef EX_MULDIV_ITER_MUL_EN
    logic        is_mul_r;
`endif

    logic        is_div_s;
    logic        is_mul_s;
    logic        iter_op_s;
    logic        launch_s;
    logic        signed_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] div_shift_s;
    logic        div_ge_s;
    logic [32:0] div_sub_s;
    logic [63:0] div_next_s;
`ifdef EX_MULDIV_ITER_MUL_EN
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
`else
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] mul_fast_s;
`endif

    // Operand decode, magnitudes and one step of the iterative datapath.
    always_comb begin
        is_div_s    = (op == OP_DIV) | (op == OP_DIVU);
        is_mul_s    = (op == OP_MULT) | (op == OP_MULTU);
`ifdef EX_MULDIV_ITER_MUL_EN
        iter_op_s   = is_div_s | is_mul_s;
`else
        iter_op_s   = is_div_s;
`endif
        launch_s    = start & (state_r == ST_IDLE) & iter_op_s;
        signed_s    = (op == OP_MULT) | (op == OP_DIV);
        a_neg_s     = signed_s & reg_a[31];
        b_neg_s     = signed_s & reg_b[31];
        a_mag_s     = a_neg_s ? neg32(reg_a) : reg_a;
        b_mag_s     = b_neg_s ? neg32(reg_b) : reg_b;
        // Restoring step: shift next dividend bit into the partial remainder.
        div_shift_s = acc_r[63:31];
        div_ge_s    = (div_shift_s >= {1'b0, opb_r});
        div_sub_s   = div_shift_s - {1'b0, opb_r};
        if (div_ge_s) begin
            div_next_s = {div_sub_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            div_next_s = {acc_r[62:0], 1'b0};
        end
`ifdef EX_MULDIV_ITER_MUL_EN
        // Shift-add step: conditionally add multiplicand, shift right.
        mul_sum_s  = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opb_r} : 33'd0);
        mul_next_s = {mul_sum_s, acc_r[31:1]};
`else
        // Sign/zero extension to 64 bits gives the correct low 64 product bits.
        ext_a_s    = {{32{a_neg_s}}, reg_a};
        ext_b_s    = {{32{b_neg_s}}, reg_b};
        mul_fast_s = ext_a_s * ext_b_s;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = launch_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_s = (cnt_r == 6'd31) ? ST_FIX : ST_RUN;
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs and stall request.
    always_comb begin
        busy  = (state_r != ST_IDLE);
        stall = busy & (start | rd_hilo);
        done  = done_r;
        hi    = hi_r;
        lo    = lo_r;
    end

    // Datapath: operand capture, iterations, sign fix and HI/LO writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            acc_r   <= 64'd0;
            opb_r   <= 32'd0;
            cnt_r   <= 6'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            done_r  <= 1'b0;
`ifdef EX_MULDIV_ITER_MUL_EN
            is_mul_r <= 1'b0;
`endif
        end else begin
            done_r <= (state_r == ST_FIX);
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 6'd0;
                    if (start) begin
                        case (op)
                            OP_MTHI: hi_r <= reg_a;
                            OP_MTLO: lo_r <= reg_a;
                            OP_MULT, OP_MULTU: begin
`ifdef EX_MULDIV_ITER_MUL_EN
                                acc_r    <= {32'd0, b_mag_s};
                                opb_r    <= a_mag_s;
                                neg_q_r  <= a_neg_s ^ b_neg_s;
                                neg_r_r  <= 1'b0;
                                is_mul_r <= 1'b1;
`else
                                {hi_r, lo_r} <= mul_fast_s;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_r   <= {32'd0, a_mag_s};
                                opb_r   <= b_mag_s;
                                // Divide by zero keeps the all-ones quotient unsigned.
                                neg_q_r <= (a_neg_s ^ b_neg_s) & (reg_b != 32'd0);
                                neg_r_r <= a_neg_s;
`ifdef EX_MULDIV_ITER_MUL_EN
                                is_mul_r <= 1'b0;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
`ifdef EX_MULDIV_ITER_MUL_EN
                    acc_r <= is_mul_r ? mul_next_s : div_next_s;
`else
                    acc_r <= div_next_s;
`endif
                    cnt_r <= cnt_r + 6'd1;
                end
                ST_FIX: begin
                    cnt_r <= 6'd0;
`ifdef EX_MULDIV_ITER_MUL_EN
                    if (is_mul_r) begin
                        {hi_r, lo_r} <= neg_q_r ? neg64(acc_r) : acc_r;
                    end else begin
                        lo_r <= neg_q_r ? neg32(acc_r[31:0]) : acc_r[31:0];
                        hi_r <= neg_r_r ? neg32(acc_r[63:32]) : acc_r[63:32];
                    end
`else
                    lo_r <= neg_q_r ? neg32(acc_r[31:0]) : acc_r[31:0];
                    hi_r <= neg_r_r ? neg32(acc_r[63:32]) : acc_r[63:32];
`endif
                end
                default: cnt_r <= 6'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: moves, divide (incl. corner cases),
// multiply latency per configuration, stall behaviour and mid-op reset.

module tb_ex_muldiv;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] reg_a;
    logic [31:0] reg_b;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int checks = 0;
    int errors = 0;

    ex_muldiv dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .reg_a   (reg_a),
        .reg_b   (reg_b),
        .rd_hilo (rd_hilo),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .stall   (stall),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then observe 40 samples (after E0..E39).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n, output int done_at,
                          output logic [63:0] first);
        op = o; reg_a = a; reg_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        first = {hi, lo};
        busy_n = 0; done_n = 0; done_at = -1;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k < 39) tick();
        end
    endtask

    int          bn, dn, da;
    logic [63:0] first;
    logic [31:0] hi0, lo0;
    int          bad_stall;
    int          done_seen;
    logic        fell;

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; reg_a = 32'd0; reg_b = 32'd0; rd_hilo = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check_val("reset_hi", {32'd0, hi}, 64'd0);
        check_val("reset_lo", {32'd0, lo}, 64'd0);
        check_val("reset_busy_done", {62'd0, busy, done}, 64'd0);

        // MTHI then MTLO on consecutive cycles
        op = 3'd4; reg_a = 32'h12345678; start = 1'b1;
        tick();
        check_val("mthi_hi", {32'd0, hi}, 64'h12345678);
        check_val("mthi_busy", {63'd0, busy}, 64'd0);
        op = 3'd5; reg_a = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        check_val("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
        check_val("mtlo_hi_kept", {32'd0, hi}, 64'h12345678);
        check_val("mtlo_busy", {63'd0, busy}, 64'd0);

        // No-op op with start is ignored
        op = 3'd6; reg_a = 32'h55555555; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("noop_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
        check_val("noop_busy", {63'd0, busy}, 64'd0);

        // DIV -7 / 2
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, bn, dn, da, first);
        check_val("div_busy_cycles", 64'(bn), 64'd33);
        check_val("div_done_count", 64'(dn), 64'd1);
        check_val("div_done_at", 64'(da), 64'd33);
        check_val("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        // DIVU 100 / 0
        run_op(3'd3, 32'd100, 32'd0, bn, dn, da, first);
        check_val("divu_zero_hilo", {hi, lo}, 64'h00000064_FFFFFFFF);

        // DIV by zero, negative dividend
        run_op(3'd2, 32'hFFFFFF00, 32'd0, bn, dn, da, first);
        check_val("div_zero_neg_hilo", {hi, lo}, 64'hFFFFFF00_FFFFFFFF);

        // DIV 0x80000000 / -1
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, bn, dn, da, first);
        check_val("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        // DIVU large unsigned: 0xFFFFFFFF / 16 = 0x0FFFFFFF r 15
        run_op(3'd3, 32'hFFFFFFFF, 32'd16, bn, dn, da, first);
        check_val("divu_big_hilo", {hi, lo}, 64'h0000000F_0FFFFFFF);

        // MULT / MULTU -1 x 2
        run_op(3'd0, 32'hFFFFFFFF, 32'h00000002, bn, dn, da, first);
        check_val("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
`ifdef EX_MULDIV_ITER_MUL_EN
        check_val("mult_busy_cycles", 64'(bn), 64'd33);
        check_val("mult_done_at", 64'(da), 64'd33);
`else
        check_val("mult_first_cycle", first, 64'hFFFFFFFF_FFFFFFFE);
        check_val("mult_busy_cycles", 64'(bn), 64'd0);
        check_val("mult_done_count", 64'(dn), 64'd0);
`endif
        run_op(3'd1, 32'hFFFFFFFF, 32'h00000002, bn, dn, da, first);
        check_val("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);
`ifdef EX_MULDIV_ITER_MUL_EN
        check_val("multu_busy_cycles", 64'(bn), 64'd33);
        check_val("multu_done_count", 64'(dn), 64'd1);
`else
        check_val("multu_first_cycle", first, 64'h00000001_FFFFFFFE);
`endif

        // Stall: DIV 1000/7, rd_hilo and a held MTHI start from cycle 5
        hi0 = hi; lo0 = lo;
        op = 3'd2; reg_a = 32'd1000; reg_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rd_hilo = 1'b1; op = 3'd4; reg_a = 32'hDEADBEEF; start = 1'b1;
        #1;
        bad_stall = 0; fell = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) begin
                fell = 1'b1;
                break;
            end
            if (stall !== 1'b1 || hi !== hi0 || lo !== lo0) bad_stall++;
            tick();
        end
        check_val("stall_busy_fell", {63'd0, fell}, 64'd1);
        check_val("stall_during_busy", 64'(bad_stall), 64'd0);
        check_val("stall_after_busy", {63'd0, stall}, 64'd0);
        check_val("stall_done", {63'd0, done}, 64'd1);
        check_val("stall_div_hilo", {hi, lo}, 64'h00000006_0000008E);
        tick();   // held MTHI accepted in the done cycle
        start = 1'b0; rd_hilo = 1'b0;
        check_val("start_in_done_cycle", {hi, lo}, 64'hDEADBEEF_0000008E);
        check_val("done_single_pulse", {63'd0, done}, 64'd0);

        // Reset at cycle 10 of a DIV
        op = 3'd2; reg_a = 32'd1000; reg_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_hilo", {hi, lo}, 64'd0);
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) done_seen++;
            tick();
        end
        check_val("abort_no_done", 64'(done_seen), 64'd0);

        // Reset overrides a simultaneous start
        op = 3'd4; reg_a = 32'hCAFEF00D; start = 1'b1; reset = 1'b1;
        tick();
        start = 1'b0; reset = 1'b0;
        check_val("reset_over_start", {32'd0, hi}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage, downstream of the ID/EX pipeline register. It consumes the decoded operation and the two register operands (`reg_a`, `reg_b`) latched by ID/EX, and owns the architectural HI/LO registers. It raises a stall request so hazard logic can freeze IF/ID and ID/EX while a multi-cycle operation runs or while a HI/LO read would see stale data.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  issue `op` this cycle; ID/EX holds a valid mul/div/move instruction
- `op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-ops
- `reg_a`  in  32  rs operand: multiplicand, dividend, or move source
- `reg_b`  in  32  rt operand: multiplier or divisor
- `rd_hilo`  in  1  instruction in EX is MFHI or MFLO
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `busy`  out  1  multi-cycle operation in progress
- `stall`  out  1  `busy & (start | rd_hilo)`, combinational
- `done`  out  1  one-cycle pulse when a multi-cycle result is written to HI/LO

## Operation
- FSM states:
  - IDLE → RUN when `start` is sampled with a multi-cycle op.
  - RUN → FIX when the 6-bit iteration counter reaches 31.
  - FIX → IDLE unconditionally.
- `start` is honoured only in IDLE. While `busy`, `start` is ignored; the upstream stall holds the instruction, which reissues in the cycle after `busy` falls.
- MTHI / MTLO: `hi` or `lo` takes `reg_a` at the sampling edge. No `busy`, no `done`.
- DIV / DIVU:
  - Restoring, 1 quotient bit per cycle, over 32 RUN cycles on operand magnitudes.
  - FIX applies signs: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Result: `lo` = quotient, `hi` = remainder.
- Divide by zero (both DIV and DIVU): `lo` = 0xFFFFFFFF, `hi` = dividend as given. No trap.
- DIV 0x80000000 / 0xFFFFFFFF: `lo` = 0x80000000, `hi` = 0.
- MULT / MULTU: 64-bit product, signed or unsigned per `op`. `{hi,lo}` = product. Timing depends on configuration (see Configuration).
- No-op values of `op` with `start` are ignored entirely.
- Operands are captured internally at the sampling edge; ID/EX may change afterwards.

## Timing
- Reset: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, FSM = IDLE, counter = 0.
- Multi-cycle op sampled at edge E0:
  - `busy` = 1 from after E0 through E33.
  - Iterations on E1..E32; FIX writes HI/LO on E33.
  - After E33: `busy` = 0, `done` = 1 for exactly one cycle, new `hi`/`lo` visible.
  - Issue-to-readable latency: 34 cycles.
- Single-cycle ops (moves, fast multiply): HI/LO written at E0, visible the next cycle. A back-to-back MFHI sees the new value with no stall.
- `stall` is combinational from `busy`, `start` and `rd_hilo`. It never depends on `op`.
- `reset` asserted mid-operation aborts it:
  - At that edge, HI/LO clear to 0 and the FSM returns to IDLE.
  - No `done` pulse is produced.
  - Reset overrides a simultaneous `start`.
- A `start` in the cycle `done` is high is accepted, since the FSM is already IDLE.

## Configuration
- `EX_MULDIV_ITER_MUL_EN` defined:
  - MULT/MULTU use the shift-add path through the same FSM: 32 RUN cycles, with FIX negating the product for signed ops with differing signs.
  - Same 34-cycle latency as divide, with `busy` and `done` behaving identically.
- Undefined:
  - MULT/MULTU are single-cycle: `{hi,lo}` written at the sampling edge, `busy` never asserted for multiply.
  - The RUN path serves only DIV/DIVU.

## Test plan
- Reset, then MTHI 0x12345678 and MTLO 0x9ABCDEF0 on consecutive cycles → `hi`/`lo` show those values one cycle after each edge; `busy` stays 0.
- DIV with `reg_a` = -7 (0xFFFFFFF9), `reg_b` = 2 → after 34 cycles `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF; `done` high for exactly 1 cycle; `busy` high for 33 cycles.
- DIVU 100 / 0 → `lo` = 0xFFFFFFFF, `hi` = 100. DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- MULT 0xFFFFFFFF × 0x00000002 → `{hi,lo}` = 0xFFFFFFFF_FFFFFFFE. MULTU with the same operands → 0x00000001_FFFFFFFE. Check 1-cycle latency without the macro and 34-cycle latency with it.
- Start DIV, assert `rd_hilo` at cycle 5 → `stall` = 1 until `busy` falls. A second `start` during `busy` → ignored, `stall` = 1, HI/LO unchanged until the first result.
- Assert `reset` at cycle 10 of a DIV → `hi` = `lo` = 0 next cycle, `busy` = 0, and no `done` pulse ever appears.
